dmi_sba_seq: RTL and testbench

Hardware sequencer that turns single 32-bit word read/write requests into the debug-module DMI transaction sequence needed to perform a system-bus access (SBCS setup, SBAddress0, SBData0, SBCS busy/error poll). It sits between an on-chip or bench-side requester and the DMI request/response port of the RISC-V debug module. It lets the SBA path be exercised and shared without a JTAG TAP in the loop. One access is in flight at a time; DMI busy and system-bus errors are handled in hardware.

---
 rtl/dmi_sba_seq.sv | 255 +++++++++++++++++++++++++
 tb/tb_dmi_sba_seq.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_sba_seq.sv
// dmi_sba_seq: turns single 32-bit word read/write requests into the DMI
// register sequence that performs one system-bus access through the debug
// module (SBCS setup, SBAddress0, SBData0, SBCS poll, optional error clear).
// One access and one DMI transaction are in flight at a time.
// Optional feature macro: SBA_SEQ_POLL_TIMEOUT_EN bounds the number of SBCS
// polls per access to MaxPolls and reports an error when the bound is hit.
module dmi_sba_seq #(
  parameter int MaxPolls = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        dmi_req_valid_o,
  input  logic        dmi_req_ready_i,
  output logic [6:0]  dmi_req_addr_o,
  output logic [1:0]  dmi_req_op_o,
  output logic [31:0] dmi_req_data_o,
  input  logic        dmi_resp_valid_i,
  output logic        dmi_resp_ready_o,
  input  logic [31:0] dmi_resp_data_i,
  input  logic [1:0]  dmi_resp_resp_i
);

  localparam logic [6:0]  ADDR_SBCS    = 7'h38;
  localparam logic [6:0]  ADDR_SBADDR0 = 7'h39;
  localparam logic [6:0]  ADDR_SBDATA0 = 7'h3C;
  localparam logic [1:0]  OP_READ      = 2'd1;
  localparam logic [1:0]  OP_WRITE     = 2'd2;
  localparam logic [1:0]  RESP_OK      = 2'd0;
  localparam logic [1:0]  RESP_BUSY    = 2'd3;
  localparam logic [31:0] CS_WRITE     = 32'h0004_0000;  // sbaccess = 32 bit
  localparam logic [31:0] CS_READ      = 32'h0014_0000;  // plus sbreadonaddr
  localparam logic [31:0] CS_CLEAR     = 32'h0040_7000;  // W1C sbbusyerror, sberror

  typedef enum logic [2:0] {
    ST_IDLE, ST_SET_CS, ST_SET_ADDR, ST_SET_DATA,
    ST_POLL, ST_GET_DATA, ST_CLR_ERR, ST_RESP
  } state_e;

  state_e      r_state, w_state_nxt;
  logic        r_wait, w_wait_nxt;          // 0 = ISSUE phase, 1 = WAIT phase
  logic        r_we, w_we_nxt;
  logic [31:0] r_addr, w_addr_nxt;
  logic [31:0] r_wdata, w_wdata_nxt;
  logic [31:0] r_rdata, w_rdata_nxt;
  logic        r_err, w_err_nxt;
  logic        r_req_ready, w_req_ready_nxt;
  logic        r_rsp_valid, w_rsp_valid_nxt;
  logic        r_dmi_req_valid, w_dmi_req_valid_nxt;
  logic        r_dmi_resp_ready, w_dmi_resp_ready_nxt;
  logic [6:0]  r_dmi_addr, w_dmi_addr_nxt;
  logic [1:0]  r_dmi_op, w_dmi_op_nxt;
  logic [31:0] r_dmi_data, w_dmi_data_nxt;
  logic        w_dmi_state;
  logic        w_sb_busy, w_sb_err;
  logic        w_unused;

`ifdef SBA_SEQ_POLL_TIMEOUT_EN
  localparam int CNT_W = $clog2(MaxPolls + 1);
  localparam logic [CNT_W-1:0] POLL_LIMIT = CNT_W'(MaxPolls);
  logic [CNT_W-1:0] r_poll_cnt, w_poll_cnt_nxt, w_poll_cnt_inc;
  assign w_poll_cnt_inc = r_poll_cnt + CNT_W'(1);
  assign w_unused       = ^req_addr_i[1:0];
`else
  assign w_unused       = ^{req_addr_i[1:0], (MaxPolls > 0)};
`endif

  assign w_sb_busy = dmi_resp_data_i[21];
  assign w_sb_err  = (|dmi_resp_data_i[14:12]) | dmi_resp_data_i[22];

  // Next-state, latched access fields and next values of all registered outputs
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    w_we_nxt    = r_we;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_rdata_nxt = r_rdata;
    w_err_nxt   = r_err;
`ifdef SBA_SEQ_POLL_TIMEOUT_EN
    w_poll_cnt_nxt = r_poll_cnt;
`endif
    case (r_state)
      ST_IDLE: begin
        if (req_valid_i && r_req_ready) begin
          w_we_nxt    = req_we_i;
          w_addr_nxt  = {req_addr_i[31:2], 2'b00};
          w_wdata_nxt = req_wdata_i;
          w_rdata_nxt = '0;
          w_err_nxt   = 1'b0;
          w_wait_nxt  = 1'b0;
          w_state_nxt = ST_SET_CS;
`ifdef SBA_SEQ_POLL_TIMEOUT_EN
          w_poll_cnt_nxt = '0;
`endif
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) w_state_nxt = ST_IDLE;
      end
      default: begin
        if (!r_wait) begin
          if (dmi_req_ready_i) w_wait_nxt = 1'b1;
        end else if (dmi_resp_valid_i) begin
          // Busy response falls back to ISSUE in the same state, which
          // re-sends the identical request.
          w_wait_nxt = 1'b0;
          if (dmi_resp_resp_i != RESP_BUSY) begin
            if (dmi_resp_resp_i != RESP_OK) begin
              w_state_nxt = ST_RESP;
              w_err_nxt   = 1'b1;
              w_rdata_nxt = '0;
            end else begin
              case (r_state)
                ST_SET_CS:   w_state_nxt = ST_SET_ADDR;
                ST_SET_ADDR: w_state_nxt = r_we ? ST_SET_DATA : ST_POLL;
                ST_SET_DATA: w_state_nxt = ST_POLL;
                ST_POLL: begin
                  if (w_sb_busy) begin
`ifdef SBA_SEQ_POLL_TIMEOUT_EN
                    w_poll_cnt_nxt = w_poll_cnt_inc;
                    if (w_poll_cnt_inc == POLL_LIMIT) begin
                      w_state_nxt = ST_CLR_ERR;
                      w_err_nxt   = 1'b1;
                    end
`endif
                  end else if (w_sb_err) begin
                    w_state_nxt = ST_CLR_ERR;
                    w_err_nxt   = 1'b1;
                  end else begin
                    w_state_nxt = r_we ? ST_RESP : ST_GET_DATA;
                  end
                end
                ST_GET_DATA: begin
                  w_rdata_nxt = dmi_resp_data_i;
                  w_state_nxt = ST_RESP;
                end
                ST_CLR_ERR: begin
                  w_err_nxt   = 1'b1;
                  w_state_nxt = ST_RESP;
                end
                default: w_state_nxt = ST_IDLE;
              endcase
            end
          end
        end
      end
    endcase

    w_dmi_state          = (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_RESP);
    w_req_ready_nxt      = (w_state_nxt == ST_IDLE);
    w_rsp_valid_nxt      = (w_state_nxt == ST_RESP);
    w_dmi_req_valid_nxt  = w_dmi_state && !w_wait_nxt;
    w_dmi_resp_ready_nxt = w_dmi_state && w_wait_nxt;

    w_dmi_addr_nxt = r_dmi_addr;
    w_dmi_op_nxt   = r_dmi_op;
    w_dmi_data_nxt = r_dmi_data;
    if (w_dmi_req_valid_nxt) begin
      case (w_state_nxt)
        ST_SET_CS: begin
          w_dmi_addr_nxt = ADDR_SBCS;
          w_dmi_op_nxt   = OP_WRITE;
          w_dmi_data_nxt = w_we_nxt ? CS_WRITE : CS_READ;
        end
        ST_SET_ADDR: begin
          w_dmi_addr_nxt = ADDR_SBADDR0;
          w_dmi_op_nxt   = OP_WRITE;
          w_dmi_data_nxt = w_addr_nxt;
        end
        ST_SET_DATA: begin
          w_dmi_addr_nxt = ADDR_SBDATA0;
          w_dmi_op_nxt   = OP_WRITE;
          w_dmi_data_nxt = w_wdata_nxt;
        end
        ST_POLL: begin
          w_dmi_addr_nxt = ADDR_SBCS;
          w_dmi_op_nxt   = OP_READ;
          w_dmi_data_nxt = '0;
        end
        ST_GET_DATA: begin
          w_dmi_addr_nxt = ADDR_SBDATA0;
          w_dmi_op_nxt   = OP_READ;
          w_dmi_data_nxt = '0;
        end
        ST_CLR_ERR: begin
          w_dmi_addr_nxt = ADDR_SBCS;
          w_dmi_op_nxt   = OP_WRITE;
          w_dmi_data_nxt = CS_CLEAR;
        end
        default: ;
      endcase
    end
  end

  // State, latched access and registered outputs; reset returns to IDLE at once
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state          <= ST_IDLE;
      r_wait           <= 1'b0;
      r_we             <= 1'b0;
      r_addr           <= '0;
      r_wdata          <= '0;
      r_rdata          <= '0;
      r_err            <= 1'b0;
      r_req_ready      <= 1'b1;
      r_rsp_valid      <= 1'b0;
      r_dmi_req_valid  <= 1'b0;
      r_dmi_resp_ready <= 1'b0;
      r_dmi_addr       <= '0;
      r_dmi_op         <= '0;
      r_dmi_data       <= '0;
`ifdef SBA_SEQ_POLL_TIMEOUT_EN
      r_poll_cnt       <= '0;
`endif
    end else begin
      r_state          <= w_state_nxt;
      r_wait           <= w_wait_nxt;
      r_we             <= w_we_nxt;
      r_addr           <= w_addr_nxt;
      r_wdata          <= w_wdata_nxt;
      r_rdata          <= w_rdata_nxt;
      r_err            <= w_err_nxt;
      r_req_ready      <= w_req_ready_nxt;
      r_rsp_valid      <= w_rsp_valid_nxt;
      r_dmi_req_valid  <= w_dmi_req_valid_nxt;
      r_dmi_resp_ready <= w_dmi_resp_ready_nxt;
      r_dmi_addr       <= w_dmi_addr_nxt;
      r_dmi_op         <= w_dmi_op_nxt;
      r_dmi_data       <= w_dmi_data_nxt;
`ifdef SBA_SEQ_POLL_TIMEOUT_EN
      r_poll_cnt       <= w_poll_cnt_nxt;
`endif
    end
  end

  assign req_ready_o      = r_req_ready;
  assign rsp_valid_o      = r_rsp_valid;
  assign rsp_rdata_o      = r_rdata;
  assign rsp_err_o        = r_err;
  assign dmi_req_valid_o  = r_dmi_req_valid;
  assign dmi_resp_ready_o = r_dmi_resp_ready;
  assign dmi_req_addr_o   = r_dmi_addr;
  assign dmi_req_op_o     = r_dmi_op;
  assign dmi_req_data_o   = r_dmi_data;

endmodule

// File: tb/tb_dmi_sba_seq.sv
// tb_dmi_sba_seq: drives word accesses into dmi_sba_seq against a small debug
// module model (SBCS poll values, SBAddress0/SBData0 memory, busy/fail
// injection). Expected DMI requests and access responses are queued when an
// access is set up and checked as the DUT emits them.
module tb_dmi_sba_seq;

`ifdef SBA_SEQ_POLL_TIMEOUT_EN
  localparam int MP = 4;
`else
  localparam int MP = 64;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i, req_ready_o, req_we_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic        dmi_req_valid_o, dmi_req_ready_i;
  logic [6:0]  dmi_req_addr_o;
  logic [1:0]  dmi_req_op_o;
  logic [31:0] dmi_req_data_o;
  logic        dmi_resp_valid_i, dmi_resp_ready_o;
  logic [31:0] dmi_resp_data_i;
  logic [1:0]  dmi_resp_resp_i;

  always #5 clk = ~clk;

  dmi_sba_seq #(.MaxPolls(MP)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_we_i         (req_we_i),
    .req_addr_i       (req_addr_i),
    .req_wdata_i      (req_wdata_i),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_ready_i      (rsp_ready_i),
    .rsp_rdata_o      (rsp_rdata_o),
    .rsp_err_o        (rsp_err_o),
    .dmi_req_valid_o  (dmi_req_valid_o),
    .dmi_req_ready_i  (dmi_req_ready_i),
    .dmi_req_addr_o   (dmi_req_addr_o),
    .dmi_req_op_o     (dmi_req_op_o),
    .dmi_req_data_o   (dmi_req_data_o),
    .dmi_resp_valid_i (dmi_resp_valid_i),
    .dmi_resp_ready_o (dmi_resp_ready_o),
    .dmi_resp_data_i  (dmi_resp_data_i),
    .dmi_resp_resp_i  (dmi_resp_resp_i)
  );

  typedef struct packed {
    logic [1:0]  op;
    logic [6:0]  addr;
    logic [31:0] data;
  } dmi_t;

  int          total = 0;
  int          bad = 0;
  dmi_t        exp_q[$];
  logic [32:0] exp_rsp_q[$];             // {err, rdata}
  logic [31:0] sbcs_q[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] sbaddr = '0;
  bit          always_busy = 0;
  bit          dmi_chk_en = 1;
  int          busy_cnt = 0;
  logic [6:0]  busy_addr = '0;
  int          fail_cnt = 0;
  logic [6:0]  fail_addr = '0;
  int          poll_seen = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_req(input logic [1:0] op, input logic [6:0] a, input logic [31:0] d);
    exp_q.push_back({op, a, d});
  endtask

  task automatic push_rsp(input logic err, input logic [31:0] rdata);
    exp_rsp_q.push_back({err, rdata});
  endtask

  // Debug module model: compare an accepted request, then answer it
  task automatic serve(input dmi_t c);
    dmi_t        e;
    logic [31:0] d;
    logic [1:0]  r;
    if (dmi_chk_en) begin
      if (exp_q.size() == 0) begin
        check("dmi_unexpected_req", {c.op, c.addr}, 0);
      end else begin
        e = exp_q.pop_front();
        check("dmi_op", c.op, e.op);
        check("dmi_addr", c.addr, e.addr);
        if (e.op == 2'd2) check("dmi_wdata", c.data, e.data);
      end
    end
    d = '0;
    r = 2'd0;
    if (c.op == 2'd1 && c.addr == 7'h38) poll_seen++;
    if (busy_cnt > 0 && c.addr == busy_addr) begin
      r = 2'd3;
      busy_cnt--;
    end else if (fail_cnt > 0 && c.addr == fail_addr) begin
      r = 2'd2;
      fail_cnt--;
    end else if (c.op == 2'd2) begin
      if (c.addr == 7'h39) sbaddr = c.data;
      else if (c.addr == 7'h3C) mem[sbaddr] = c.data;
    end else if (c.addr == 7'h38) begin
      if (always_busy) d = 32'h0020_0000;
      else if (sbcs_q.size() > 0) d = sbcs_q.pop_front();
    end else if (c.addr == 7'h3C) begin
      if (mem.exists(sbaddr)) d = mem[sbaddr];
    end
    dmi_resp_data_i  = d;
    dmi_resp_resp_i  = r;
    dmi_resp_valid_i = 1'b1;
  endtask

  // DMI responder: answers one cycle after acceptance, drops valid after handshake
  initial begin
    dmi_t cap;
    bit   req_pend;
    bit   rsp_pend;
    req_pend = 0;
    rsp_pend = 0;
    cap = '0;
    dmi_resp_valid_i = 1'b0;
    dmi_resp_data_i  = '0;
    dmi_resp_resp_i  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        req_pend = 0;
        rsp_pend = 0;
        dmi_resp_valid_i = 1'b0;
      end else begin
        if (rsp_pend) dmi_resp_valid_i = 1'b0;
        if (req_pend) serve(cap);
        req_pend = dmi_req_valid_o && dmi_req_ready_i;
        cap      = {dmi_req_op_o, dmi_req_addr_o, dmi_req_data_o};
        rsp_pend = dmi_resp_valid_i && dmi_resp_ready_o;
      end
    end
  end

  // One access: request handshake, wait for response, compare, release
  task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input int lat, input int hold);
    int          cyc;
    logic [32:0] e;
    req_we_i    = we;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    req_valid_i = 1'b1;
    cyc = 0;
    while (!req_ready_o && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("req_ready_idle", req_ready_o, 1);
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    req_addr_i  = ~addr;
    req_wdata_i = ~wdata;
    check("req_ready_busy", req_ready_o, 0);
    cyc = 1;
    while (!rsp_valid_o && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!rsp_valid_o) begin
      check("rsp_timeout", 0, 1);
    end else begin
      if (lat != 0) check("rsp_latency", cyc, lat);
      if (exp_rsp_q.size() == 0) begin
        check("rsp_unexpected", 1, 0);
        e = '0;
      end else begin
        e = exp_rsp_q.pop_front();
      end
      req_valid_i = (hold > 0);
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        check("rsp_hold_valid", rsp_valid_o, 1);
        check("rsp_hold_noaccept", req_ready_o, 0);
      end
      req_valid_i = 1'b0;
      check("rsp_err", rsp_err_o, e[32]);
      check("rsp_rdata", rsp_rdata_o, e[31:0]);
      rsp_ready_i = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready_i = 1'b0;
      check("rsp_released", rsp_valid_o, 0);
      check("back_to_idle", req_ready_o, 1);
    end
    check("dmi_seq_left", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req_valid_i = 1'b0;
    req_we_i = 1'b0;
    req_addr_i = '0;
    req_wdata_i = '0;
    rsp_ready_i = 1'b0;
    dmi_req_ready_i = 1'b1;
    mem[32'h0000_2004] = 32'h1234_5678;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready_o, 1);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_dmi_req_valid", dmi_req_valid_o, 0);
    check("rst_dmi_resp_ready", dmi_resp_ready_o, 0);
    check("rst_rsp_rdata", rsp_rdata_o, 0);
    check("rst_rsp_err", rsp_err_o, 0);
    check("rst_dmi_fields", {dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Ideal write
    push_req(2'd2, 7'h38, 32'h0004_0000);
    push_req(2'd2, 7'h39, 32'h0000_1000);
    push_req(2'd2, 7'h3C, 32'hDEAD_BEEF);
    push_req(2'd1, 7'h38, 32'h0);
    push_rsp(1'b0, 32'h0);
    run_access(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 9, 0);

    // Ideal read
    push_req(2'd2, 7'h38, 32'h0014_0000);
    push_req(2'd2, 7'h39, 32'h0000_2004);
    push_req(2'd1, 7'h38, 32'h0);
    push_req(2'd1, 7'h3C, 32'h0);
    push_rsp(1'b0, 32'h1234_5678);
    run_access(1'b0, 32'h0000_2004, 32'h0, 9, 0);

    // Unaligned address is forced to word, response held while upstream stalls
    push_req(2'd2, 7'h38, 32'h0014_0000);
    push_req(2'd2, 7'h39, 32'h0000_1000);
    push_req(2'd1, 7'h38, 32'h0);
    push_req(2'd1, 7'h3C, 32'h0);
    push_rsp(1'b0, 32'hDEAD_BEEF);
    run_access(1'b0, 32'h0000_1003, 32'h0, 9, 3);

    // sbbusy three times then clear
    sbcs_q = '{32'h0020_0000, 32'h0020_0000, 32'h0020_0000, 32'h0};
    push_req(2'd2, 7'h38, 32'h0004_0000);
    push_req(2'd2, 7'h39, 32'h0000_3000);
    push_req(2'd2, 7'h3C, 32'hA5A5_0001);
    for (int i = 0; i < 4; i++) push_req(2'd1, 7'h38, 32'h0);
    push_rsp(1'b0, 32'h0);
    run_access(1'b1, 32'h0000_3000, 32'hA5A5_0001, 15, 0);

    // sberror = 2 on a read
    sbcs_q = '{32'h0000_2000};
    push_req(2'd2, 7'h38, 32'h0014_0000);
    push_req(2'd2, 7'h39, 32'h0000_2004);
    push_req(2'd1, 7'h38, 32'h0);
    push_req(2'd2, 7'h38, 32'h0040_7000);
    push_rsp(1'b1, 32'h0);
    run_access(1'b0, 32'h0000_2004, 32'h0, 9, 0);

    // sbbusyerror on a write
    sbcs_q = '{32'h0040_0000};
    push_req(2'd2, 7'h38, 32'h0004_0000);
    push_req(2'd2, 7'h39, 32'h0000_3004);
    push_req(2'd2, 7'h3C, 32'h0000_0077);
    push_req(2'd1, 7'h38, 32'h0);
    push_req(2'd2, 7'h38, 32'h0040_7000);
    push_rsp(1'b1, 32'h0);
    run_access(1'b1, 32'h0000_3004, 32'h0000_0077, 11, 0);

    // DMI busy on SBAddress0 write: identical request re-issued
    busy_cnt  = 1;
    busy_addr = 7'h39;
    push_req(2'd2, 7'h38, 32'h0004_0000);
    push_req(2'd2, 7'h39, 32'h0000_4008);
    push_req(2'd2, 7'h39, 32'h0000_4008);
    push_req(2'd2, 7'h3C, 32'h0000_CAFE);
    push_req(2'd1, 7'h38, 32'h0);
    push_rsp(1'b0, 32'h0);
    run_access(1'b1, 32'h0000_4008, 32'h0000_CAFE, 11, 0);

    // DMI failure on the SBData0 read: error, no clear write, rdata 0
    fail_cnt  = 1;
    fail_addr = 7'h3C;
    push_req(2'd2, 7'h38, 32'h0014_0000);
    push_req(2'd2, 7'h39, 32'h0000_2004);
    push_req(2'd1, 7'h38, 32'h0);
    push_req(2'd1, 7'h3C, 32'h0);
    push_rsp(1'b1, 32'h0);
    run_access(1'b0, 32'h0000_2004, 32'h0, 9, 0);

`ifdef SBA_SEQ_POLL_TIMEOUT_EN
    // Permanent sbbusy: poll bound reached, then clear and error
    always_busy = 1;
    push_req(2'd2, 7'h38, 32'h0004_0000);
    push_req(2'd2, 7'h39, 32'h0000_5000);
    push_req(2'd2, 7'h3C, 32'h0000_0001);
    for (int i = 0; i < 4; i++) push_req(2'd1, 7'h38, 32'h0);
    push_req(2'd2, 7'h38, 32'h0040_7000);
    push_rsp(1'b1, 32'h0);
    run_access(1'b1, 32'h0000_5000, 32'h0000_0001, 17, 0);
    always_busy = 0;
`endif

    // Reset while polling
    always_busy = 1;
    dmi_chk_en  = 0;
    poll_seen   = 0;
    req_we_i    = 1'b1;
    req_addr_i  = 32'h0000_6000;
    req_wdata_i = 32'h0000_0002;
    req_valid_i = 1'b1;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    for (int i = 0; i < 100 && poll_seen < 2; i++) begin
      @(posedge clk);
      #1;
    end
    check("poll_reached", poll_seen >= 2, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_req_ready", req_ready_o, 1);
    check("rst_mid_dmi_req_valid", dmi_req_valid_o, 0);
    check("rst_mid_dmi_resp_ready", dmi_resp_ready_o, 0);
    check("rst_mid_rsp_valid", rsp_valid_o, 0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    always_busy = 0;
    dmi_chk_en  = 1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("post_rst_idle", req_ready_o, 1);
    check("post_rst_dmi_quiet", dmi_req_valid_o, 0);

    // Clean access after reset
    push_req(2'd2, 7'h38, 32'h0004_0000);
    push_req(2'd2, 7'h39, 32'h0000_7000);
    push_req(2'd2, 7'h3C, 32'h0BAD_F00D);
    push_req(2'd1, 7'h38, 32'h0);
    push_rsp(1'b0, 32'h0);
    run_access(1'b1, 32'h0000_7000, 32'h0BAD_F00D, 9, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
